instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: request fields are valid.
REQ-004 SHALL have port in_ready, output, 1 bit: encoder accepts the request this cycle.
REQ-005 SHALL have port op, input, 3 bits: 0 lw, 1 sw, 2 R-type, 3 beq, 4 I-type ALU, 5-7 unsupported.
REQ-006 SHALL have port funct3, input, 3 bits: ALU funct3 for op 2/4; ignored for other op values.
REQ-007 SHALL have port f7b5, input, 1 bit: funct7 bit 5 for op 2 (sub/sra); ignored for other op values.
REQ-008 SHALL have ports rd, rs1 and rs2, input, 5 bits each: register indices.
REQ-009 SHALL have port imm, input, 13 bits: signed immediate; bits [11:0] are used for op 0/1/4, bits [12:1] for op 3.
REQ-010 SHALL have port flush, input, 1 bit: synchronous clear of the output entry and the address counter.
REQ-011 SHALL have port out_valid, output, 1 bit: an encoded word is held.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer takes the word.
REQ-013 SHALL have port out_instr, output, 32 bits: encoded RV32I word.
REQ-014 SHALL have port out_addr, output, 32 bits: byte address of out_instr.
REQ-015 SHALL have port err, output, 1 bit: sticky unsupported-request flag.

Function
REQ-016 SHALL encode each op as follows:
- op 0: {imm[11:0], rs1, 010, rd, 0000011}
- op 1: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}
- op 2: {0, f7b5, 00000, rs2, rs1, funct3, rd, 0110011}
- op 3: {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011}
- op 4: {imm[11:0], rs1, funct3, rd, 0010011}
REQ-017 SHALL hold one output entry as a 2-state FSM (EMPTY, FULL); in_ready = EMPTY or (FULL and out_ready).
REQ-018 SHALL treat a transfer as accepted when in_valid and in_ready are both high; the encoded word appears on out_instr one cycle later with out_valid high (latency 1).
REQ-019 SHALL perform FSM transitions as follows:
- EMPTY to FULL on accept.
- FULL to EMPTY on out_ready without accept.
- Stay FULL on simultaneous out_ready and accept (the new word replaces the old one, no bubble).
REQ-020 SHALL hold out_instr and out_addr stable while out_valid=1 and out_ready=0.
REQ-021 SHALL use an address counter starting at 0; each emitted word takes the current count as out_addr, then the counter increments by 4 and wraps from 0xFFFFFFFC to 0.
REQ-022 SHALL, on flush, go to EMPTY, set the counter to 0 and drop any accept in the same cycle; err is unchanged.
REQ-023 SHALL keep in_ready low during a flush cycle.

Reset
REQ-024 SHALL, on rst asserted, immediately set out_valid=0, out_instr=0, out_addr=0, counter=0, err=0 and FSM=EMPTY.
REQ-025 SHALL drop an entry that is held FULL when rst asserts; it is not re-emitted.
REQ-026 SHALL resume normal operation on the first clock edge after rst is deasserted.

Configuration
REQ-027 SHALL, when ENC_RANGE_CHECK_EN is defined:
- accept unsupported op values (5-7) without emitting a word and without advancing the counter, and set err;
- also treat op 3 with imm[0]=1 as unsupported.
REQ-028 SHALL, when ENC_RANGE_CHECK_EN is undefined:
- encode op 5-7 as the NOP 0x00000013 and emit it normally;
- ignore imm[0] for op 3;
- tie err to 0.

Verification
REQ-029 SHALL cover: after reset, op=0, rd=5, rs1=2, imm=8 -> out_instr=0x00812283, out_addr=0.
REQ-030 SHALL cover: a back-to-back stream with out_ready=1 of sw(rs2=5, rs1=2, imm=8), R(f7b5=1, funct3=0, rd=3, rs1=1, rs2=2), beq(rs1=1, rs2=2, imm=8) -> 0x00512423@0, 0x402081B3@4, 0x00208463@8, with no bubbles.
REQ-031 SHALL cover: out_ready=0 after one accept -> in_ready=0 and the held word stays stable; raising out_ready together with a new request (addi rd=1, imm=5) -> next word 0x00500093 with no idle cycle.
REQ-032 SHALL cover: op=6 -> with ENC_RANGE_CHECK_EN, nothing emitted, err=1 and the counter unchanged; without it, 0x00000013 emitted.
REQ-033 SHALL cover: rst pulsed while FULL at out_addr=0x10 -> out_valid=0 at once, and the next emitted word has out_addr=0.
REQ-034 SHALL cover: flush together with in_valid -> request dropped and the next word at out_addr=0.

Source files
------------

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Turns a compact request (op selector plus register/immediate fields) into a
// 32-bit RV32I instruction word. The word goes into a one-entry output buffer
// with a valid/ready handshake, and each word is stamped with a byte address
// from a running counter.
//
// Supported op values:
//   0 lw, 1 sw, 2 R-type ALU, 3 beq, 4 I-type ALU, 5-7 unsupported
//
// Build option (macro ENC_RANGE_CHECK_EN):
//   defined   : ops 5-7, and beq with imm[0]=1, are consumed without emitting
//               a word or advancing the counter, and the sticky err flag is set.
//   undefined : ops 5-7 are emitted as the canonical NOP (addi x0,x0,0),
//               imm[0] is ignored for beq, and err is tied low.
//
// Ports:
//   clk        in   clock; all state changes on the rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   request fields are valid
//   in_ready   out  request is accepted this cycle
//   op         in   [2:0]  operation selector
//   funct3     in   [2:0]  ALU funct3 for ops 2 and 4
//   f7b5       in   funct7 bit 5 for op 2 (sub/sra)
//   rd         in   [4:0]  destination register
//   rs1        in   [4:0]  source register 1
//   rs2        in   [4:0]  source register 2
//   imm        in   [12:0] signed immediate
//   flush      in   synchronous clear of the output entry and the counter
//   out_valid  out  an encoded word is held
//   out_ready  in   consumer takes the word
//   out_instr  out  [31:0] encoded word
//   out_addr   out  [31:0] byte address of out_instr
//   err        out  sticky unsupported-request flag
// ---------------------------------------------------------------------------
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [2:0]  funct3,
    input  logic        f7b5,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err
);

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [31:0] ADDR_STEP = 32'd4;

    localparam logic [2:0] OP_LW   = 3'd0;
    localparam logic [2:0] OP_SW   = 3'd1;
    localparam logic [2:0] OP_R    = 3'd2;
    localparam logic [2:0] OP_BEQ  = 3'd3;
    localparam logic [2:0] OP_IALU = 3'd4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state_reg;
    logic [31:0] instr_reg;
    logic [31:0] addr_reg;
    logic [31:0] count_reg;

    logic [31:0] word_next;
    logic        unsupported;
    logic        accept;

    // -----------------------------------------------------------------------
    // Combinational encoder
    // -----------------------------------------------------------------------
    always_comb begin
        word_next = NOP_WORD;
        unique case (op)
            OP_LW:   word_next = {imm[11:0], rs1, F3_WORD, rd, OPC_LOAD};
            OP_SW:   word_next = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
            OP_R:    word_next = {1'b0, f7b5, 5'b00000, rs2, rs1, funct3, rd, OPC_OP};
            // Branch offsets are in units of 2 bytes, so imm[0] never lands
            // in the word; the scrambled B-type layout is fixed by the ISA.
            OP_BEQ:  word_next = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                                  imm[4:1], imm[11], OPC_BRANCH};
            OP_IALU: word_next = {imm[11:0], rs1, funct3, rd, OPC_OPIMM};
            default: word_next = NOP_WORD;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // A misaligned branch offset cannot be represented, so it is rejected
    // along with the undefined op values.
    assign unsupported = (op > OP_IALU) || ((op == OP_BEQ) && imm[0]);
`else
    assign unsupported = 1'b0;
    // imm[0] is meaningless when the range check is compiled out.
    logic unused_imm0;
    assign unused_imm0 = imm[0];
`endif

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    // The buffer can take a new request when it is empty or when the held
    // word is leaving this same cycle. A flush blocks acceptance outright so
    // the upstream source keeps its request rather than losing it.
    assign in_ready = !flush && ((state_reg == EMPTY) || out_ready);
    assign accept   = in_valid && in_ready;

    // -----------------------------------------------------------------------
    // Output-entry FSM, address counter and sticky error
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
            instr_reg <= '0;
            addr_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            state_reg <= EMPTY;
            instr_reg <= '0;
            addr_reg  <= '0;
            count_reg <= '0;
        end else if (accept && !unsupported) begin
            // Covers both EMPTY->FULL and the FULL->FULL replace case where
            // the old word drains and the new one loads in the same edge.
            state_reg <= FULL;
            instr_reg <= word_next;
            addr_reg  <= count_reg;
            count_reg <= count_reg + ADDR_STEP;  // wraps naturally at 2^32
        end else if (accept) begin
            // Unsupported request consumed without a word: whatever was held
            // has drained (accept while FULL implies out_ready).
            state_reg <= EMPTY;
        end else if ((state_reg == FULL) && out_ready) begin
            state_reg <= EMPTY;
        end
    end

`ifdef ENC_RANGE_CHECK_EN
    logic err_reg;

    // Kept apart from the flush path: only reset clears the error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (!flush && accept && unsupported) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign out_valid = (state_reg == FULL);
    assign out_instr = instr_reg;
    assign out_addr  = addr_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed-vector bench for instr_encoder. Inputs are driven one time unit
// after the rising edge; outputs are sampled there too, after the edge that
// should have produced them. Expected words are hand-encoded constants.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;

    int total = 0;
    int bad   = 0;

    instr_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .funct3    (funct3),
        .f7b5      (f7b5),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] o, input logic [2:0] f3,
                           input logic f7, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2,
                           input logic [12:0] im);
        op     = o;
        funct3 = f3;
        f7b5   = f7;
        rd     = d;
        rs1    = s1;
        rs2    = s2;
        imm    = im;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        set_req(3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 13'd0);

        // ---------------- reset state ----------------
        tick();
        tick();
        check_val("rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_instr", out_instr, 32'd0);
        check_val("rst_addr",  out_addr,  32'd0);
        check_val("rst_err",   {31'd0, err}, 32'd0);
        rst = 1'b0;
        tick();

        // ---------------- lw after reset ----------------
        set_req(3'd0, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8);
        in_valid = 1'b1;
        #1;
        check_val("lw_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check_val("lw_valid", {31'd0, out_valid}, 32'd1);
        check_val("lw_instr", out_instr, 32'h0081_2283);
        check_val("lw_addr",  out_addr,  32'd0);
        out_ready = 1'b1;
        tick();
        check_val("lw_drained", {31'd0, out_valid}, 32'd0);

        // ---------------- back-to-back stream ----------------
        pulse_rst();
        tick();
        out_ready = 1'b1;
        set_req(3'd1, 3'd0, 1'b0, 5'd0, 5'd2, 5'd5, 13'd8);   // sw
        in_valid = 1'b1;
        tick();
        check_val("b2b_sw_instr", out_instr, 32'h0051_2423);
        check_val("b2b_sw_addr",  out_addr,  32'd0);
        set_req(3'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 13'd0);   // sub
        #1;
        check_val("b2b_r_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check_val("b2b_r_instr", out_instr, 32'h4020_81B3);
        check_val("b2b_r_addr",  out_addr,  32'd4);
        set_req(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 13'd8);   // beq
        tick();
        check_val("b2b_beq_valid", {31'd0, out_valid}, 32'd1);
        check_val("b2b_beq_instr", out_instr, 32'h0020_8463);
        check_val("b2b_beq_addr",  out_addr,  32'd8);
        in_valid = 1'b0;
        tick();
        check_val("b2b_drained", {31'd0, out_valid}, 32'd0);

        // ---------------- backpressure then replace ----------------
        out_ready = 1'b0;
        set_req(3'd0, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8);
        in_valid = 1'b1;
        tick();
        set_req(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 13'd5);   // addi, blocked
        #1;
        check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check_val("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        check_val("bp_hold_instr", out_instr, 32'h0081_2283);
        check_val("bp_hold_addr",  out_addr,  32'd12);
        out_ready = 1'b1;
        #1;
        check_val("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check_val("bp_addi_valid", {31'd0, out_valid}, 32'd1);
        check_val("bp_addi_instr", out_instr, 32'h0050_0093);
        check_val("bp_addi_addr",  out_addr,  32'd16);
        in_valid = 1'b0;
        tick();

        // ---------------- unsupported op 6 ----------------
        set_req(3'd6, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 13'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
        check_val("op6_no_emit", {31'd0, out_valid}, 32'd0);
        check_val("op6_err",     {31'd0, err}, 32'd1);
`else
        check_val("op6_nop_valid", {31'd0, out_valid}, 32'd1);
        check_val("op6_nop_instr", out_instr, 32'h0000_0013);
        check_val("op6_nop_addr",  out_addr,  32'd20);
        check_val("op6_err",       {31'd0, err}, 32'd0);
`endif
        tick();
        set_req(3'd0, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
        check_val("op6_next_addr", out_addr, 32'd20);
`else
        check_val("op6_next_addr", out_addr, 32'd24);
`endif
        tick();

        // ---------------- reset while FULL at 0x10 ----------------
        pulse_rst();
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("rf_full_addr",  out_addr, 32'h10);
        check_val("rf_full_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("rf_async_valid", {31'd0, out_valid}, 32'd0);
        check_val("rf_async_addr",  out_addr, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check_val("rf_not_reemitted", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        check_val("rf_next_addr",  out_addr, 32'd0);
        check_val("rf_next_valid", {31'd0, out_valid}, 32'd1);
        tick();

        // ---------------- flush with in_valid ----------------
        in_valid = 1'b1;
        tick();                      // word at 4 emitted, counter now 8
        flush = 1'b1;
        set_req(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 13'd5);
        #1;
        check_val("fl_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_val("fl_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check_val("fl_dropped", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_val("fl_next_instr", out_instr, 32'h0050_0093);
        check_val("fl_next_addr",  out_addr,  32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
